// File: rtl/async_upordowncounter_t_ff.sv
// rtl/async_upordowncounter_t_ff.sv - single T flip-flop with synchronous active-high reset
module t_ff (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic qbar
);

    // Power-up value keeps q defined before the first reset edge.
    logic q_r = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= 1'b0;
        end else if (t) begin
            q_r <= ~q_r;
        end
    end

    assign q    = q_r;
    assign qbar = ~q_r;

endmodule

// File: rtl/async_upordowncounter.sv
// rtl/async_upordowncounter.sv - up/down counter built from a T flip-flop chain in one clock domain
module async_upordowncounter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    logic [WIDTH-1:0] tog;
    logic             all_ones;
    logic             all_zeros;

    // Bit i toggles when every lower bit is 1 (counting up) or 0 (counting down).
    always_comb begin
        tog       = '0;
        all_ones  = 1'b1;
        all_zeros = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            all_ones  = 1'b1;
            all_zeros = 1'b1;
            for (int j = 0; j < i; j++) begin
                all_ones  = all_ones & q[j];
                all_zeros = all_zeros & ~q[j];
            end
            tog[i] = t & (up ? all_ones : all_zeros);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_ff u_t_ff (
            .clk  (clk),
            .rst  (rst),
            .t    (tog[i]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

endmodule

// File: tb/tb_async_upordowncounter.sv
// tb/tb_async_upordowncounter.sv - directed checks of the up/down counter at WIDTH=2 and WIDTH=4
module tb_async_upordowncounter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       t   = 1'b0;
    logic       up  = 1'b0;
    logic [1:0] q2;
    logic [1:0] qbar2;
    logic [3:0] q4;
    logic [3:0] qbar4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    async_upordowncounter #(.WIDTH(2)) dut2 (
        .clk  (clk),
        .rst  (rst),
        .t    (t),
        .up   (up),
        .q    (q2),
        .qbar (qbar2)
    );

    async_upordowncounter #(.WIDTH(4)) dut4 (
        .clk  (clk),
        .rst  (rst),
        .t    (t),
        .up   (up),
        .q    (q4),
        .qbar (qbar4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic tt, input logic u);
        rst = r;
        t   = tt;
        up  = u;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e2, input logic [3:0] e4);
        chk({tag, "_q2"}, {30'b0, q2}, {30'b0, e2});
        chk({tag, "_qbar2"}, {30'b0, qbar2}, {30'b0, ~e2});
        chk({tag, "_q4"}, {28'b0, q4}, {28'b0, e4});
        chk({tag, "_qbar4"}, {28'b0, qbar4}, {28'b0, ~e4});
    endtask

    logic [1:0] up_seq2 [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] dn_seq2 [8] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};

    initial begin
        #1;
        chk_all("powerup", 2'd0, 4'd0);

        // Up count from power-up; WIDTH=4 runs 16 edges to reach its wrap.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk_all($sformatf("up%0d", i), up_seq2[(i - 1) % 8], 4'(i % 16));
        end

        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk_all($sformatf("dn%0d", i), dn_seq2[(i - 1) % 8], 4'((16 - i) % 16));
        end

        step(1'b0, 1'b1, 1'b1);
        chk_all("pre_rst", 2'd1, 4'd1);
        step(1'b1, 1'b1, 1'b1);
        chk_all("rst", 2'd0, 4'd0);
        step(1'b0, 1'b1, 1'b1);
        chk_all("rst_rel", 2'd1, 4'd1);

        step(1'b0, 1'b1, 1'b1);
        chk_all("to_2", 2'd2, 4'd2);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, i[0]);
            chk_all($sformatf("hold%0d", i), 2'd2, 4'd2);
        end

        step(1'b0, 1'b1, 1'b1);
        chk_all("to_3", 2'd3, 4'd3);
        step(1'b0, 1'b1, 1'b0);
        chk_all("dirchg", 2'd2, 4'd2);
        step(1'b1, 1'b1, 1'b0);
        chk_all("midrst", 2'd0, 4'd0);
        step(1'b0, 1'b1, 1'b0);
        chk_all("post_midrst", 2'd3, 4'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/async_upordowncounter.md
ASYNC_UPORDOWNCOUNTER -- requirements
Module: async_upordowncounter

Interface
REQ-001 SHALL have parameter WIDTH, default 2, counter width in bits (legal range 1..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port t  input  1  count enable (toggle input of the T flip-flop chain).
REQ-005 SHALL have port up  input  1  direction: 1 = count up, 0 = count down.
REQ-006 SHALL have port q  output  WIDTH  registered count value.
REQ-007 SHALL have port qbar  output  WIDTH  bitwise complement of q.

Function
REQ-008 SHALL update q only on rising clk edges. There SHALL be no derived or ripple clocks; the ripple chain SHALL be modelled as per-bit toggle enables in the single clk domain.
REQ-009 SHALL use this bit-0 toggle rule: bit 0 SHALL toggle on every edge where rst=0 and t=1.
REQ-010 SHALL use this up-count rule for bit i>0: with up=1, bit i SHALL toggle when t=1 and q[i-1:0] are all 1.
REQ-011 SHALL use this down-count rule for bit i>0: with up=0, bit i SHALL toggle when t=1 and q[i-1:0] are all 0.
REQ-012 SHALL, as a net effect, make q increment by 1 modulo 2^WIDTH per edge when t=1 and up=1, and decrement by 1 modulo 2^WIDTH when t=1 and up=0.
REQ-013 SHALL wrap around without flag or stall: up from 2^WIDTH-1 goes to 0; down from 0 goes to 2^WIDTH-1 (WIDTH=2: 3->0, 0->3).
REQ-014 SHALL hold q unchanged on any edge where t=0 and rst=0, regardless of up.
REQ-015 SHALL sample up on the same edge as t. A direction change SHALL take effect on the first edge at which the new value is sampled, with no lost or extra count.
REQ-016 SHALL keep qbar equal to ~q at all times; qbar SHALL be driven combinationally from q or registered in lockstep, never lagging by a cycle.
REQ-017 SHALL have zero latency: the new q SHALL be visible immediately after the clock edge that applies the count.

Reset
REQ-018 SHALL give rst priority over t and up: on a rising edge with rst=1, q becomes 0 and qbar becomes all ones.
REQ-019 SHALL abandon an in-progress count when rst is asserted mid-count. The first edge with rst=0 SHALL then count from 0.
REQ-020 SHALL give all q registers an initial (power-up/configuration) value of 0, so q is defined before any reset edge occurs.

Structure
REQ-021 SHALL contain one sub-module, t_ff: a single T flip-flop with inputs clk, rst, toggle enable and outputs q, qbar. It SHALL be instantiated WIDTH times through a generate loop.
REQ-022 SHALL compute the per-bit toggle-enable chain (all-ones and all-zeros prefix terms, selected by up) in the top module.
REQ-023 SHALL be standalone: no shared package is required. WIDTH's default and the reset value 0 are the only constants and SHALL stay local.

Verification
REQ-024 Reset: rst=1 for one edge with t=1, up=1 -> q=00, qbar=11 after the edge. Release rst -> next edge q=01.
REQ-025 Up count: from power-up, t=1, up=1 for 8 edges -> q sequence 01,10,11,00,01,10,11,00, with qbar=~q at every edge.
REQ-026 Down count: from q=00, t=1, up=0 for 8 edges -> q sequence 11,10,01,00,11,10,01,00.
REQ-027 Hold: q=10, t=0, toggling up for 4 edges -> q stays 10, qbar stays 01.
REQ-028 Direction change: at q=11 with up=1, switch to up=0 before the next edge -> q=10 (no wrap to 00). Reset mid-count at q=10 -> q=00.
REQ-029 Width: rerun REQ-025 and REQ-026 with WIDTH=4 -> 0..15 wraps to 0 going up, 0 wraps to 15 going down.
